// File: rtl/controlador_varredura_pkg.sv
// Shared definitions for the scan controller: FSM encoding, default widths
// and the position of each vertex field inside a packed triangle record.
package controlador_varredura_pkg;

    localparam int LARG_COORD = 11;
    localparam int LARG_END   = 4;
    localparam int N_CAMPOS   = 6;
    localparam int LARG_TRI   = N_CAMPOS * LARG_COORD;

    // Field index inside the record; bit offset = index * coordinate width.
    localparam int CAMPO_P1X = 0;
    localparam int CAMPO_P1Y = 1;
    localparam int CAMPO_P2X = 2;
    localparam int CAMPO_P2Y = 3;
    localparam int CAMPO_P3X = 4;
    localparam int CAMPO_P3Y = 5;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        TESTA   = 2'd1,
        ENTREGA = 2'd2,
        FIM     = 2'd3
    } estado_t;

    function automatic int ofs_campo(input int campo, input int largura_coord);
        return campo * largura_coord;
    endfunction

endpackage

// File: rtl/teste_triangulo.sv
// Combinational point-in-triangle test: the point is inside when the three
// edge orientation signs agree.
module teste_triangulo #(
    parameter int COORD_W = 11
) (
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] v1x,
    input  logic [COORD_W-1:0] v1y,
    input  logic [COORD_W-1:0] v2x,
    input  logic [COORD_W-1:0] v2y,
    input  logic [COORD_W-1:0] v3x,
    input  logic [COORD_W-1:0] v3y,
    output logic               dentro
);

    localparam int DW = COORD_W + 1;
    localparam int MW = 2 * DW;

    // Coordinates are unsigned; one extra bit keeps differences exact.
    function automatic logic lado(
        input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
        input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by,
        input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy
    );
        logic signed [DW-1:0] d_acx, d_bcy, d_bcx, d_acy;
        logic signed [MW-1:0] m1, m2;
        d_acx = $signed({1'b0, ax}) - $signed({1'b0, cx});
        d_bcy = $signed({1'b0, by}) - $signed({1'b0, cy});
        d_bcx = $signed({1'b0, bx}) - $signed({1'b0, cx});
        d_acy = $signed({1'b0, ay}) - $signed({1'b0, cy});
        m1 = MW'(d_acx) * MW'(d_bcy);
        m2 = MW'(d_bcx) * MW'(d_acy);
        return m1 < m2;
    endfunction

    logic s1, s2, s3;

    always_comb begin
        s1 = lado(px, py, v1x, v1y, v2x, v2y);
        s2 = lado(px, py, v2x, v2y, v3x, v3y);
        s3 = lado(px, py, v3x, v3y, v1x, v1y);
        dentro = (s1 == s2) && (s2 == s3);
    end

endmodule

// File: rtl/controlador_varredura.sv
// Raster scan controller: for each pixel walks the triangle ROM until the
// first hit (or the end of the list) and hands the colour downstream.
module controlador_varredura
    import controlador_varredura_pkg::*;
#(
    parameter int COORD_W = LARG_COORD,
    parameter int ADDR_W  = LARG_END
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inicio,
    input  logic [COORD_W-1:0]           largura,
    input  logic [COORD_W-1:0]           altura,
    output logic [ADDR_W-1:0]            rom_endereco,
    input  logic [N_CAMPOS*COORD_W-1:0]  rom_triangulo,
    input  logic [ADDR_W-1:0]            rom_qtde,
    output logic [COORD_W-1:0]           pix_x,
    output logic [COORD_W-1:0]           pix_y,
    output logic                         pix_cor,
    output logic                         pix_valido,
    input  logic                         pix_pronto,
    output logic                         ocupado,
    output logic                         concluido
);

    estado_t            estado;
    logic [COORD_W-1:0] larg_r;
    logic [COORD_W-1:0] alt_r;
    logic               acerto;
    logic               ultimo_x;
    logic               ultimo_y;

    teste_triangulo #(.COORD_W(COORD_W)) u_teste (
        .px     (pix_x),
        .py     (pix_y),
        .v1x    (rom_triangulo[ofs_campo(CAMPO_P1X, COORD_W) +: COORD_W]),
        .v1y    (rom_triangulo[ofs_campo(CAMPO_P1Y, COORD_W) +: COORD_W]),
        .v2x    (rom_triangulo[ofs_campo(CAMPO_P2X, COORD_W) +: COORD_W]),
        .v2y    (rom_triangulo[ofs_campo(CAMPO_P2Y, COORD_W) +: COORD_W]),
        .v3x    (rom_triangulo[ofs_campo(CAMPO_P3X, COORD_W) +: COORD_W]),
        .v3y    (rom_triangulo[ofs_campo(CAMPO_P3Y, COORD_W) +: COORD_W]),
        .dentro (acerto)
    );

    assign ultimo_x = (pix_x == larg_r - COORD_W'(1));
    assign ultimo_y = (pix_y == alt_r - COORD_W'(1));

    // Valid/ready: a pixel transfers on a cycle where pix_valido and
    // pix_pronto are both high; pix_valido never drops before that cycle and
    // pix_x/pix_y/pix_cor stay frozen while it waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado       <= OCIOSO;
            rom_endereco <= '0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_cor      <= 1'b0;
            pix_valido   <= 1'b0;
            ocupado      <= 1'b0;
            concluido    <= 1'b0;
            larg_r       <= '0;
            alt_r        <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        larg_r       <= largura;
                        alt_r        <= altura;
                        pix_x        <= '0;
                        pix_y        <= '0;
                        pix_cor      <= 1'b0;
                        rom_endereco <= '0;
                        ocupado      <= 1'b1;
                        if (largura == '0 || altura == '0) begin
                            estado    <= FIM;
                            concluido <= 1'b1;
                        end else begin
                            estado <= TESTA;
                        end
                    end
                end
                TESTA: begin
                    if (rom_endereco >= rom_qtde) begin
                        pix_cor    <= 1'b0;
                        pix_valido <= 1'b1;
                        estado     <= ENTREGA;
                    end else if (acerto) begin
                        pix_cor    <= 1'b1;
                        pix_valido <= 1'b1;
                        estado     <= ENTREGA;
                    end else begin
                        rom_endereco <= rom_endereco + ADDR_W'(1);
                    end
                end
                ENTREGA: begin
                    if (pix_pronto) begin
                        pix_valido <= 1'b0;
                        if (ultimo_x) begin
                            pix_x <= '0;
                            pix_y <= pix_y + COORD_W'(1);
                        end else begin
                            pix_x <= pix_x + COORD_W'(1);
                        end
                        if (ultimo_x && ultimo_y) begin
                            estado    <= FIM;
                            concluido <= 1'b1;
                        end else begin
                            estado       <= TESTA;
                            rom_endereco <= '0;
                        end
                    end
                end
                FIM: begin
                    concluido <= 1'b0;
                    ocupado   <= 1'b0;
                    estado    <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_varredura.sv
// Bench for controlador_varredura: a high-level raster/triangle model fills
// an expected queue; a monitor pops it on every pixel transfer.
module tb_controlador_varredura;
    import controlador_varredura_pkg::*;

    localparam int CW = LARG_COORD;
    localparam int AW = LARG_END;
    localparam int PW = 2 * CW + 1 + AW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              inicio = 1'b0;
    logic [CW-1:0]     largura = '0;
    logic [CW-1:0]     altura = '0;
    logic [AW-1:0]     rom_endereco;
    logic [6*CW-1:0]   rom_triangulo;
    logic [AW-1:0]     rom_qtde = '0;
    logic [CW-1:0]     pix_x;
    logic [CW-1:0]     pix_y;
    logic              pix_cor;
    logic              pix_valido;
    logic              pix_pronto = 1'b0;
    logic              ocupado;
    logic              concluido;

    always #5 clk = ~clk;

    controlador_varredura dut (
        .clk           (clk),
        .rst           (rst),
        .inicio        (inicio),
        .largura       (largura),
        .altura        (altura),
        .rom_endereco  (rom_endereco),
        .rom_triangulo (rom_triangulo),
        .rom_qtde      (rom_qtde),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_cor       (pix_cor),
        .pix_valido    (pix_valido),
        .pix_pronto    (pix_pronto),
        .ocupado       (ocupado),
        .concluido     (concluido)
    );

    // Triangle ROM: behavioural coordinates plus the packed image the DUT reads.
    int            tri_m [16][6];
    logic [6*CW-1:0] tri_rom [16];
    assign rom_triangulo = tri_rom[rom_endereco];

    logic [PW-1:0] exp_q [$];
    int            lat_q [$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            conc_cnt = 0;
    int            modo_pronto = 0;
    bit            perturba = 1'b0;
    bit            pedir_inicio = 1'b0;

    task automatic verifica(input string nome, input logic [63:0] obtido, input logic [63:0] esperado);
        n_chk++;
        if (obtido !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, obtido, esperado, $time);
        end
    endtask

    task automatic grava_tri(input int i, input int ax, input int ay, input int bx,
                             input int by, input int cx, input int cy);
        tri_m[i][0] = ax; tri_m[i][1] = ay; tri_m[i][2] = bx;
        tri_m[i][3] = by; tri_m[i][4] = cx; tri_m[i][5] = cy;
        tri_rom[i] = {CW'(cy), CW'(cx), CW'(by), CW'(bx), CW'(ay), CW'(ax)};
    endtask

    // Orientation of (a,b,c) as plain integer arithmetic.
    function automatic bit lado(input int ax, input int ay, input int bx, input int by,
                                input int cx, input int cy);
        return (ax - cx) * (by - cy) < (bx - cx) * (ay - cy);
    endfunction

    function automatic bit dentro_modelo(input int px, input int py, input int t);
        bit s1, s2, s3;
        s1 = lado(px, py, tri_m[t][0], tri_m[t][1], tri_m[t][2], tri_m[t][3]);
        s2 = lado(px, py, tri_m[t][2], tri_m[t][3], tri_m[t][4], tri_m[t][5]);
        s3 = lado(px, py, tri_m[t][4], tri_m[t][5], tri_m[t][0], tri_m[t][1]);
        return (s1 == s2) && (s2 == s3);
    endfunction

    // Expected pixel stream: raster order, colour = any hit, k = first hit or count.
    task automatic prever(input int w, input int h, input int q);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                int  k;
                bit  cor;
                k = q;
                cor = 1'b0;
                for (int t = 0; t < q; t++) begin
                    if (!cor && dentro_modelo(x, y, t)) begin
                        k = t;
                        cor = 1'b1;
                    end
                end
                exp_q.push_back({CW'(x), CW'(y), cor, AW'(k)});
                lat_q.push_back(k + 1);
            end
        end
    endtask

    // Input drivers, offset from the active edge.
    always @(posedge clk) begin
        #1;
        case (modo_pronto)
            0:       pix_pronto = 1'b1;
            1:       pix_pronto = ($urandom_range(0, 2) != 0);
            default: pix_pronto = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        #2;
        inicio = pedir_inicio ||
                 (perturba && (pix_valido || concluido) && ($urandom_range(0, 1) == 1));
    end

    // Monitor: pops expectations on transfers, checks latency and stalls.
    int            espera = 0;
    logic          valido_ant = 1'b0;
    logic          pronto_ant = 1'b0;
    logic          conc_ant = 1'b0;
    logic [CW-1:0] x_ant = '0;
    logic [CW-1:0] y_ant = '0;
    logic          cor_ant = 1'b0;

    always @(negedge clk) begin
        if (rst || !ocupado) begin
            espera = 0;
        end
        if (!rst) begin
            if (concluido) begin
                conc_cnt++;
                verifica("concluido_one_cycle", 64'(conc_ant), 64'd0);
                verifica("all_pixels_before_end", 64'(exp_q.size()), 64'd0);
                espera = 0;
            end
            if (pix_valido && !valido_ant) begin
                if (lat_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_pix_valido: got x=%0d y=%0d expected none", pix_x, pix_y);
                end else begin
                    verifica("latency", 64'(espera), 64'(lat_q.pop_front()));
                end
                espera = 0;
            end
            if (valido_ant && !pronto_ant) begin
                verifica("stall_stable", {pix_valido, pix_x, pix_y, pix_cor},
                         {1'b1, x_ant, y_ant, cor_ant});
            end
            if (pix_valido && pix_pronto) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL extra_pixel: got x=%0d y=%0d expected none", pix_x, pix_y);
                end else begin
                    verifica("pixel_xy_cor_k", 64'({pix_x, pix_y, pix_cor, rom_endereco}),
                             64'(exp_q.pop_front()));
                end
            end
            if (ocupado && !pix_valido && !concluido) espera++;
        end
        valido_ant = pix_valido;
        pronto_ant = pix_pronto;
        conc_ant   = concluido;
        x_ant      = pix_x;
        y_ant      = pix_y;
        cor_ant    = pix_cor;
    end

    task automatic pulso_inicio();
        @(posedge clk); #1 pedir_inicio = 1'b1;
        @(posedge clk); #1 pedir_inicio = 1'b0;
    endtask

    task automatic run_scan(input int w, input int h, input int q, input bit pert,
                            input int modo, input bit pausa);
        int alvo;
        int ciclos;
        @(posedge clk); #1;
        largura = CW'(w);
        altura = CW'(h);
        rom_qtde = AW'(q);
        modo_pronto = pausa ? 2 : modo;
        perturba = pert;
        prever(w, h, q);
        alvo = conc_cnt + 1;
        pulso_inicio();
        if (pausa) begin
            ciclos = 0;
            while (!pix_valido && ciclos < 200) begin @(negedge clk); ciclos++; end
            verifica("stall_reached_valid", 64'(pix_valido), 64'd1);
            repeat (5) @(negedge clk);
            verifica("stall_still_valid", 64'(pix_valido), 64'd1);
            verifica("stall_no_advance", 64'({pix_x, pix_y}), 64'd0);
            modo_pronto = modo;
        end
        ciclos = 0;
        while (conc_cnt < alvo && ciclos < 5000) begin @(negedge clk); ciclos++; end
        verifica("scan_completed", 64'(conc_cnt), 64'(alvo));
        repeat (4) @(negedge clk);
        perturba = 1'b0;
        verifica("idle_after_scan", 64'(ocupado), 64'd0);
        verifica("single_concluido", 64'(conc_cnt), 64'(alvo));
        exp_q.delete();
        lat_q.delete();
    endtask

    initial begin
        int alvo;
        int ciclos;
        for (int i = 0; i < 16; i++) grava_tri(i, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        verifica("reset_outputs", 64'({rom_endereco, pix_x, pix_y, pix_cor, pix_valido, ocupado, concluido}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single triangle over a 3x3 raster, downstream always ready.
        grava_tri(0, 1, 1, 5, 1, 1, 5);
        run_scan(3, 3, 1, 1'b0, 0, 1'b0);

        // First triangle far away, second the same as above: hits at k=1.
        grava_tri(0, 8, 8, 12, 8, 8, 12);
        grava_tri(1, 1, 1, 5, 1, 1, 5);
        grava_tri(2, 0, 0, 7, 0, 0, 7);
        run_scan(1, 1, 3, 1'b0, 0, 1'b0);
        run_scan(3, 3, 3, 1'b0, 1, 1'b0);

        // Empty ROM: every pixel is background with minimal latency.
        run_scan(2, 2, 0, 1'b0, 1, 1'b0);

        // Downstream stalls on the first pixel.
        run_scan(2, 2, 3, 1'b0, 0, 1'b1);

        // Zero width: straight to the end pulse, no pixels.
        @(posedge clk); #1;
        largura = '0;
        altura = CW'(4);
        rom_qtde = AW'(3);
        alvo = conc_cnt + 1;
        pulso_inicio();
        @(negedge clk);
        verifica("zero_dim_concluido", 64'(concluido), 64'd1);
        @(negedge clk);
        verifica("zero_dim_pulse_end", 64'(concluido), 64'd0);
        verifica("zero_dim_count", 64'(conc_cnt), 64'(alvo));
        repeat (3) @(negedge clk);
        verifica("zero_dim_idle", 64'({ocupado, pix_valido}), 64'd0);

        // Reset while testing pixel (1,0): scan discarded, no end pulse.
        @(posedge clk); #1;
        largura = CW'(3);
        altura = CW'(3);
        rom_qtde = AW'(3);
        modo_pronto = 0;
        prever(3, 3, 3);
        alvo = conc_cnt;
        pulso_inicio();
        ciclos = 0;
        while (!(pix_valido && pix_pronto) && ciclos < 200) begin @(negedge clk); ciclos++; end
        verifica("first_transfer_seen", 64'(pix_valido && pix_pronto), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        verifica("mid_reset_outputs", 64'({rom_endereco, pix_x, pix_y, pix_cor, pix_valido, ocupado, concluido}), 64'd0);
        repeat (3) @(negedge clk);
        verifica("mid_reset_no_concluido", 64'(conc_cnt), 64'(alvo));
        run_scan(3, 3, 3, 1'b0, 1, 1'b0);

        // Same scan with inicio noise during ENTREGA and FIM.
        run_scan(3, 3, 3, 1'b1, 1, 1'b0);

        // Random triangles, sizes and back-pressure, with inicio noise.
        for (int n = 0; n < 8; n++) begin
            int q;
            q = $urandom_range(0, 6);
            for (int t = 0; t < 7; t++) begin
                grava_tri(t, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            end
            run_scan($urandom_range(1, 5), $urandom_range(1, 5), q, 1'b1, 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
